// File: rtl/mem_bus_pkg.sv
// Shared data-memory bus definitions: arbiter states and the store/load width codes
// also decoded by ControlUnit and the RAM byte/half logic.
package mem_bus_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

    localparam int STORE_TYPE_W = 2;
    localparam int LOAD_TYPE_W  = 3;

    localparam logic [STORE_TYPE_W-1:0] ST_BYTE = 2'd0;
    localparam logic [STORE_TYPE_W-1:0] ST_HALF = 2'd1;
    localparam logic [STORE_TYPE_W-1:0] ST_WORD = 2'd2;

    localparam logic [LOAD_TYPE_W-1:0] LT_BYTE_S = 3'd0;
    localparam logic [LOAD_TYPE_W-1:0] LT_HALF_S = 3'd1;
    localparam logic [LOAD_TYPE_W-1:0] LT_WORD   = 3'd2;
    localparam logic [LOAD_TYPE_W-1:0] LT_BYTE_U = 3'd3;
    localparam logic [LOAD_TYPE_W-1:0] LT_HALF_U = 3'd4;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter with clear/increment; tc flags the last denied
// cycle tolerated before a forced external grant.
module arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    // MAX_WAIT=0 still needs a 1-bit register; tc is then held low.
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] TC_VAL = CW'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);
    localparam logic [CW-1:0] SAT    = '1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (MAX_WAIT > 0) && (cnt == TC_VAL);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data RAM port between the single-cycle CPU (priority) and one external
// master; a starvation counter forces a one-cycle CPU stall so the external side progresses.
module data_mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [AW-1:0]           cpu_addr,
    input  logic [DW-1:0]           cpu_wdata,
    input  logic [STORE_TYPE_W-1:0] cpu_storeType,
    input  logic [LOAD_TYPE_W-1:0]  cpu_loadType,
    output logic [DW-1:0]           cpu_rdata,
    output logic                    cpu_stall,
    input  logic                    ext_req,
    input  logic                    ext_we,
    input  logic [AW-1:0]           ext_addr,
    input  logic [DW-1:0]           ext_wdata,
    input  logic [STORE_TYPE_W-1:0] ext_storeType,
    input  logic [LOAD_TYPE_W-1:0]  ext_loadType,
    output logic                    ext_gnt,
    output logic                    ext_rvalid,
    output logic [DW-1:0]           ext_rdata,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic                    mem_we,
    output logic [STORE_TYPE_W-1:0] mem_storeType,
    output logic [LOAD_TYPE_W-1:0]  mem_loadType,
    input  logic [DW-1:0]           mem_rdata
);

    arb_state_e state, state_next;
    logic       cnt_clr, cnt_inc, cnt_tc;
    logic       own_ext;

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        ext_gnt    = 1'b0;
        own_ext    = 1'b0;
        case (state)
            ARB: begin
                ext_gnt = ext_req & ~cpu_req;
                own_ext = ext_req & ~cpu_req;
                if (ext_req && cpu_req) begin
                    if (cnt_tc) begin
                        state_next = FORCE;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            FORCE: begin
                // Stall cycle belongs to the external port even if it dropped its request.
                ext_gnt    = ext_req;
                own_ext    = 1'b1;
                state_next = ARB;
                cnt_clr    = 1'b1;
            end
            default: begin
                state_next = ARB;
                cnt_clr    = 1'b1;
            end
        endcase

        if (own_ext) begin
            mem_addr      = ext_addr;
            mem_wdata     = ext_wdata;
            mem_we        = ext_we & ext_req;
            mem_storeType = ext_storeType;
            mem_loadType  = ext_loadType;
        end else begin
            mem_addr      = cpu_addr;
            mem_wdata     = cpu_wdata;
            mem_we        = cpu_we & cpu_req;
            mem_storeType = cpu_storeType;
            mem_loadType  = cpu_loadType;
        end
    end

    assign cpu_stall = (state == FORCE);
    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_rvalid <= ext_req & ext_gnt & ~ext_we;
            if (ext_req && ext_gnt && !ext_we) begin
                ext_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory port between the CPU core's load/store path and one external requester (debug/DMA/program loader).
- The CPU normally wins every conflict, because the single-cycle core cannot wait.
- A starvation counter forces a one-cycle CPU stall so the external port always makes progress.
- Sits between CPU_Core/external master and the data RAM. It also forwards storeType/loadType to the RAM's byte/half handling.

Parameters:
- MAX_WAIT, 4: cycles ext_req may be denied before a forced grant. 0 disables forcing (CPU strict priority).
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU load or store this cycle
- cpu_we  in  1  CPU store
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_storeType  in  2  CPU store width code
- cpu_loadType  in  3  CPU load extension code
- cpu_rdata  out  DW  load data to CPU (combinational from mem_rdata)
- cpu_stall  out  1  CPU must hold PC and suppress its access this cycle
- ext_req  in  1  external access request; held stable until granted
- ext_we  in  1  external write
- ext_addr  in  AW  external address
- ext_wdata  in  DW  external write data
- ext_storeType  in  2  external store width code
- ext_loadType  in  3  external load extension code
- ext_gnt  out  1  transfer occurs this cycle (ext_req & ext_gnt)
- ext_rvalid  out  1  ext_rdata valid, one cycle after a granted read
- ext_rdata  out  DW  registered read data for external port
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_we  out  1  RAM write enable
- mem_storeType  out  2  RAM store width code
- mem_loadType  out  3  RAM load extension code
- mem_rdata  in  DW  RAM combinational read data

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous, active-high.
- Reset values: state=ARB, wait_cnt=0, cpu_stall=0, ext_rvalid=0, ext_rdata=0. ext_gnt=0 because it is gated by state and ext_req.
- State ARB:
  - owner=CPU if cpu_req, else EXT if ext_req, else none.
  - ext_gnt = ext_req & ~cpu_req. Simultaneous requests: CPU wins.
- State FORCE:
  - Lasts exactly one cycle; cpu_stall=1 (registered, decoded from state).
  - owner=EXT; ext_gnt=ext_req regardless of cpu_req.
  - Returns to ARB next cycle.
- Mux:
  - mem_* driven from the owner's signals.
  - mem_we = owner_we & owner_req. With no owner, mem_we=0 and the other outputs carry CPU values.
  - cpu_rdata = mem_rdata always.
- Starvation counter:
  - In ARB, wait_cnt increments each cycle with ext_req=1 and ext_gnt=0.
  - Clears on any ext grant or when ext_req=0.
  - When wait_cnt==MAX_WAIT-1 and the request is still denied, next state=FORCE and wait_cnt clears.
  - Saturating; never wraps. MAX_WAIT=0: FORCE unreachable.
- Read return: on a granted ext read (ext_req & ext_gnt & ~ext_we), the next cycle gives ext_rvalid=1 and ext_rdata=mem_rdata captured at grant. Otherwise ext_rvalid=0. Back-to-back grants produce back-to-back rvalid.
- ext_req dropped during FORCE (protocol violation): cycle still stalls the CPU; mem_we=0, no transfer, no rvalid.
- Reset mid-operation: everything returns to reset values immediately. A pending rvalid is lost, and a stall in progress is released.
- CPU side: during cpu_stall, CPU_Core must not advance the PC or commit its register-file write. The arbiter additionally blocks CPU mem_we.

Decomposition:
- Shared package mem_bus_pkg:
  - arb_state_e {ARB, FORCE}
  - storeType and loadType width localparams (2 and 3) and their named codes (byte/half/word, signed/unsigned), shared with ControlUnit.
- One sub-module is natural: arb_wait_counter (saturating counter with clear, increment and terminal-count flag, width $clog2(MAX_WAIT+1)).

Test Plan:
- Reset asserted mid-FORCE → cpu_stall, ext_rvalid, ext_gnt all 0 within the same cycle; state=ARB after release.
- cpu_req=0, ext_req=1 ext_we=0 ext_addr=0x40, mem_rdata=0xDEADBEEF → ext_gnt=1 same cycle; next cycle ext_rvalid=1, ext_rdata=0xDEADBEEF.
- cpu_req=1 cpu_we=1 cpu_addr=0x10 and ext_req=1 simultaneously → mem_addr=0x10, mem_we=1, ext_gnt=0, cpu_stall=0.
- MAX_WAIT=4, cpu_req held 1, ext_req held 1 with ext write to 0x80 → 4 denied cycles, then cpu_stall=1 and ext_gnt=1 with mem_addr=0x80, mem_we=1 for one cycle, then CPU owns again.
- MAX_WAIT=0, both requests held 20 cycles → cpu_stall never asserts, ext_gnt stays 0.
- Ext back-to-back reads 0x0, 0x4, 0x8 with cpu_req=0 → three consecutive ext_rvalid pulses carrying the matching data. mem_storeType/loadType equal ext codes during those grants.
